sid_env_mux: RTL and testbench

Time-multiplexed, parametrised ADSR envelope generator for the SID voice path. It serves `VOICES` independent envelopes from one shared update datapath, one voice per clock in round-robin order. It adds two things the single-voice linear envelope lacks: configurable envelope width, and an optional exponential decay/release curve. It sits between the voice register file (config writes, gate bits) and the per-voice amplitude multipliers feeding the mixer/PWM stage.

---
 rtl/sid_env_mux.sv | 192 +++++++++++++++++++
 tb/tb_sid_env_mux.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_env_mux.sv
// Time-multiplexed ADSR envelope generator: one shared update datapath services one voice
// per clock in round-robin order, with optional exponential decay/release stretching.
module sid_env_mux #(
    parameter int unsigned VOICES = 3,
    parameter int unsigned ENV_W  = 8,
    parameter bit          EXP_EN = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [2:0]                cfg_voice,
    input  logic                      cfg_addr,
    input  logic [7:0]                cfg_data,
    input  logic [VOICES-1:0]         gate,
    output logic [VOICES*ENV_W-1:0]   env_out,
    output logic                      upd_strobe,
    output logic [2:0]                upd_voice,
    output logic [2:0]                upd_state
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAttack  = 3'd1,
        StDecay   = 3'd2,
        StSustain = 3'd3,
        StRelease = 3'd4
    } state_e;

    localparam logic [2:0]       LastSlot  = 3'(VOICES - 1);
    localparam logic [3:0]       NumVoices = 4'(VOICES);
    localparam logic [ENV_W-1:0] EnvMax    = '1;

    // Per-voice storage
    state_e            state_q   [VOICES];
    logic [ENV_W-1:0]  env_q     [VOICES];
    logic [19:0]       cnt_q     [VOICES];
    logic [3:0]        attack_q  [VOICES];
    logic [3:0]        decay_q   [VOICES];
    logic [3:0]        sustain_q [VOICES];
    logic [3:0]        release_q [VOICES];
    logic [VOICES-1:0] gate_prev_q;
    logic [2:0]        slot_q;

    // Shared update datapath, operating on voice slot_q
    state_e            cur_state;
    state_e            nxt_state;
    logic [ENV_W-1:0]  cur_env;
    logic [ENV_W-1:0]  nxt_env;
    logic [ENV_W-1:0]  sus;
    logic [19:0]       cur_cnt;
    logic [19:0]       nxt_cnt;
    logic              gate_now;
    logic              gate_was;
    logic [3:0]        rate;
    logic [2:0]        shift;
    logic [4:0]        exp_sh;
    logic [20:0]       thr;
    logic              step;
    logic [15:0]       sus_rep;
    logic [ENV_W+4:0]  env_pad;

    always_comb begin
        cur_state = state_q[slot_q];
        cur_env   = env_q[slot_q];
        cur_cnt   = cnt_q[slot_q];
        gate_now  = gate[slot_q];
        gate_was  = gate_prev_q[slot_q];

        sus_rep = {4{sustain_q[slot_q]}};
        sus     = sus_rep[15 -: ENV_W];

        // Ones padding below env caps the leading-zero count at 5 even for narrow envelopes.
        env_pad = {cur_env, 5'b11111};
        shift   = 3'd5;
        for (int i = 4; i >= 0; i--) begin
            if (env_pad[ENV_W+4-i]) begin
                shift = 3'(i);
            end
        end
        if (!(EXP_EN && (cur_state == StDecay || cur_state == StRelease))) begin
            shift = 3'd0;
        end

        case (cur_state)
            StAttack:  rate = attack_q[slot_q];
            StDecay:   rate = decay_q[slot_q];
            StRelease: rate = release_q[slot_q];
            default:   rate = 4'd0;
        endcase

        exp_sh = {1'b0, rate} + {2'b00, shift};
        thr    = (21'd1 << exp_sh) - 21'd1;
        step   = ({1'b0, cur_cnt} >= thr);

        nxt_state = cur_state;
        nxt_env   = cur_env;
        nxt_cnt   = cur_cnt;

        if (gate_now && !gate_was) begin
            // Env is kept so a retrigger resumes from the current level.
            nxt_state = StAttack;
            nxt_cnt   = '0;
        end else if (!gate_now && gate_was) begin
            if (cur_state != StIdle) begin
                nxt_state = StRelease;
                nxt_cnt   = '0;
            end
        end else begin
            case (cur_state)
                StAttack, StDecay, StRelease: begin
                    if (step) begin
                        nxt_cnt = '0;
                        case (cur_state)
                            StAttack: begin
                                if (cur_env != EnvMax) begin
                                    nxt_env = cur_env + 1'b1;
                                end
                                if (nxt_env == EnvMax) begin
                                    nxt_state = StDecay;
                                end
                            end
                            StDecay: begin
                                if (cur_env > sus) begin
                                    nxt_env = cur_env - 1'b1;
                                end
                                if (nxt_env <= sus) begin
                                    nxt_state = StSustain;
                                end
                            end
                            default: begin
                                if (cur_env != '0) begin
                                    nxt_env = cur_env - 1'b1;
                                end
                                if (nxt_env == '0) begin
                                    nxt_state = StIdle;
                                end
                            end
                        endcase
                    end else begin
                        nxt_cnt = cur_cnt + 20'd1;
                    end
                end
                default: nxt_cnt = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VOICES; v++) begin
                state_q[v]   <= StIdle;
                env_q[v]     <= '0;
                cnt_q[v]     <= '0;
                attack_q[v]  <= '0;
                decay_q[v]   <= '0;
                sustain_q[v] <= '0;
                release_q[v] <= '0;
            end
            gate_prev_q <= '0;
            slot_q      <= '0;
            upd_strobe  <= 1'b0;
            upd_voice   <= '0;
            upd_state   <= '0;
        end else begin
            state_q[slot_q]     <= nxt_state;
            env_q[slot_q]       <= nxt_env;
            cnt_q[slot_q]       <= nxt_cnt;
            gate_prev_q[slot_q] <= gate_now;
            slot_q              <= (slot_q == LastSlot) ? 3'd0 : slot_q + 3'd1;
            upd_strobe          <= 1'b1;
            upd_voice           <= slot_q;
            upd_state           <= nxt_state;
            if (cfg_we && ({1'b0, cfg_voice} < NumVoices)) begin
                if (!cfg_addr) begin
                    attack_q[cfg_voice] <= cfg_data[7:4];
                    decay_q[cfg_voice]  <= cfg_data[3:0];
                end else begin
                    sustain_q[cfg_voice] <= cfg_data[7:4];
                    release_q[cfg_voice] <= cfg_data[3:0];
                end
            end
        end
    end

    always_comb begin
        env_out = '0;
        for (int v = 0; v < VOICES; v++) begin
            env_out[v*ENV_W +: ENV_W] = env_q[v];
        end
    end

endmodule

// File: tb/tb_sid_env_mux.sv
// Bench for sid_env_mux: a linear and an exponential instance share stimulus and are checked
// against a per-voice behavioural envelope model plus directed timing counts.
module tb_sid_env_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_voice = '0;
    logic        cfg_addr = 1'b0;
    logic [7:0]  cfg_data = '0;
    logic [2:0]  gate = '0;

    logic [23:0] env_l, env_e;
    logic        stb_l, stb_e;
    logic [2:0]  uv_l, uv_e, us_l, us_e;
    logic [30:0] obs_l, obs_e;

    assign obs_l = {stb_l, uv_l, us_l, env_l};
    assign obs_e = {stb_e, uv_e, us_e, env_e};

    always #5 clk = ~clk;

    sid_env_mux #(.VOICES(3), .ENV_W(8), .EXP_EN(1'b0)) dut_lin (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .gate(gate), .env_out(env_l), .upd_strobe(stb_l),
        .upd_voice(uv_l), .upd_state(us_l)
    );

    sid_env_mux #(.VOICES(3), .ENV_W(8), .EXP_EN(1'b1)) dut_exp (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .gate(gate), .env_out(env_e), .upd_strobe(stb_e),
        .upd_voice(uv_e), .upd_state(us_e)
    );

    // Model: index 0 = linear instance, 1 = exponential instance
    int m_state [2][3];
    int m_env   [2][3];
    int m_cnt   [2][3];
    int m_gp    [2][3];
    int m_att [3], m_dec [3], m_sus [3], m_rel [3];
    int m_slot, m_strobe, m_uvoice;
    int m_ustate [2];
    int cyc = 0;
    int last_sv = 0;
    int n_cmp = 0;
    int n_fail = 0;

    function automatic void model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int v = 0; v < 3; v++) begin
                m_state[k][v] = 0; m_env[k][v] = 0; m_cnt[k][v] = 0; m_gp[k][v] = 0;
            end
            m_ustate[k] = 0;
        end
        for (int v = 0; v < 3; v++) begin
            m_att[v] = 0; m_dec[v] = 0; m_sus[v] = 0; m_rel[v] = 0;
        end
        m_slot = 0; m_strobe = 0; m_uvoice = 0;
    endfunction

    // Extra exponent from the level band the envelope currently sits in.
    function automatic int stretch(int env);
        if (env >= 128) return 0;
        if (env >= 64) return 1;
        if (env >= 32) return 2;
        if (env >= 16) return 3;
        if (env >= 8) return 4;
        return 5;
    endfunction

    function automatic void model_service(int k, int v);
        int g, st, env, rate, period;
        g = int'(gate[v]);
        st = m_state[k][v];
        env = m_env[k][v];
        if (g == 1 && m_gp[k][v] == 0) begin
            st = 1; m_cnt[k][v] = 0;
        end else if (g == 0 && m_gp[k][v] == 1 && st != 0) begin
            st = 4; m_cnt[k][v] = 0;
        end else if (st == 1 || st == 2 || st == 4) begin
            rate = (st == 1) ? m_att[v] : (st == 2) ? m_dec[v] : m_rel[v];
            period = 1 << (rate + ((k == 1 && st != 1) ? stretch(env) : 0));
            if (m_cnt[k][v] + 1 >= period) begin
                m_cnt[k][v] = 0;
                if (st == 1) begin
                    if (env < 255) env++;
                    if (env == 255) st = 2;
                end else if (st == 2) begin
                    if (env > m_sus[v] * 17) env--;
                    if (env <= m_sus[v] * 17) st = 3;
                end else begin
                    if (env > 0) env--;
                    if (env == 0) st = 0;
                end
            end else begin
                m_cnt[k][v]++;
            end
        end
        m_state[k][v] = st;
        m_env[k][v] = env;
        m_gp[k][v] = g;
        m_ustate[k] = st;
    endfunction

    function automatic logic [30:0] exp_vec(int k);
        logic [23:0] e;
        for (int v = 0; v < 3; v++) e[v*8 +: 8] = 8'(m_env[k][v]);
        return {1'(m_strobe), 3'(m_uvoice), 3'(m_ustate[k]), e};
    endfunction

    task automatic tick();
        @(posedge clk);
        last_sv = m_slot;
        if (!rst) begin
            model_service(0, m_slot);
            model_service(1, m_slot);
            m_uvoice = m_slot;
            m_strobe = 1;
            if (cfg_we && cfg_voice < 3'd3) begin
                if (!cfg_addr) begin
                    m_att[cfg_voice] = int'(cfg_data[7:4]); m_dec[cfg_voice] = int'(cfg_data[3:0]);
                end else begin
                    m_sus[cfg_voice] = int'(cfg_data[7:4]); m_rel[cfg_voice] = int'(cfg_data[3:0]);
                end
            end
            m_slot = (m_slot + 1) % 3;
        end
        cyc++;
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic cfg_write(int v, int a, int d);
        cfg_we = 1'b1; cfg_voice = 3'(v); cfg_addr = a[0]; cfg_data = 8'(d);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        gate = '0;
        #1;
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_cmp += 2;
        if (obs_l !== 31'h0) begin n_fail++; $display("FAIL reset_lin: got %h want 0", obs_l); end
        if (obs_e !== 31'h0) begin n_fail++; $display("FAIL reset_exp: got %h want 0", obs_e); end
        @(posedge clk);
        #1;
        n_cmp++;
        if (obs_l !== 31'h0) begin n_fail++; $display("FAIL reset_held: got %h want 0", obs_l); end
        model_clear();
        rst = 1'b0;
        tick();
        n_cmp += 2;
        if (obs_l !== exp_vec(0)) begin n_fail++; $display("FAIL first_service_lin: got %h want %h", obs_l, exp_vec(0)); end
        if (obs_e !== exp_vec(1)) begin n_fail++; $display("FAIL first_service_exp: got %h want %h", obs_e, exp_vec(1)); end
    endtask

    task automatic test_attack_decay();
        int svc = 0, ff_at = -1, sus_at = -1;
        do_reset();
        cfg_write(0, 0, 8'h00);
        cfg_write(0, 1, 8'hA0);
        gate[0] = 1'b1;
        for (int t = 0; t < 1500 && sus_at < 0; t++) begin
            tick();
            n_cmp += 2;
            if (obs_l !== exp_vec(0)) begin n_fail++; $display("FAIL ad_lin cyc=%0d: got %h want %h", cyc, obs_l, exp_vec(0)); end
            if (obs_e !== exp_vec(1)) begin n_fail++; $display("FAIL ad_exp cyc=%0d: got %h want %h", cyc, obs_e, exp_vec(1)); end
            if (last_sv == 0) begin
                svc++;
                if (ff_at < 0 && env_l[7:0] == 8'hFF) begin
                    ff_at = svc;
                    n_cmp++;
                    if (us_l !== 3'd2) begin n_fail++; $display("FAIL attack_to_decay: got %0d want 2", us_l); end
                end
                if (us_l == 3'd3) sus_at = svc;
            end
        end
        n_cmp += 3;
        if (ff_at != 256) begin n_fail++; $display("FAIL attack_len: got %0d want 256", ff_at); end
        if (sus_at - ff_at != 85) begin n_fail++; $display("FAIL decay_len: got %0d want 85", sus_at - ff_at); end
        if (env_l !== 24'h0000AA) begin n_fail++; $display("FAIL sustain_env: got %h want 0000aa", env_l); end
    endtask

    task automatic test_release();
        int svc = 0;
        bit done = 0;
        gate[0] = 1'b0;
        for (int t = 0; t < 1000 && !done; t++) begin
            tick();
            n_cmp++;
            if (obs_l !== exp_vec(0)) begin n_fail++; $display("FAIL rel_lin cyc=%0d: got %h want %h", cyc, obs_l, exp_vec(0)); end
            if (last_sv == 0) begin
                svc++;
                if (svc == 1) begin
                    n_cmp++;
                    if (us_l !== 3'd4) begin n_fail++; $display("FAIL release_entry: got %0d want 4", us_l); end
                end
                if (env_l[7:0] == 8'h40) done = 1;
            end
        end
        n_cmp++;
        if (svc != 107) begin n_fail++; $display("FAIL release_to_40: got %0d want 107", svc); end
        gate[0] = 1'b1;
        done = 0;
        for (int t = 0; t < 3 && !done; t++) begin
            tick();
            if (last_sv == 0) done = 1;
        end
        n_cmp += 2;
        if (us_l !== 3'd1) begin n_fail++; $display("FAIL retrigger_state: got %0d want 1", us_l); end
        if (env_l[7:0] !== 8'h40) begin n_fail++; $display("FAIL retrigger_env: got %h want 40", env_l[7:0]); end
        done = 0;
        for (int t = 0; t < 3000 && !done; t++) begin
            tick();
            n_cmp += 2;
            if (obs_l !== exp_vec(0)) begin n_fail++; $display("FAIL rt_lin cyc=%0d: got %h want %h", cyc, obs_l, exp_vec(0)); end
            if (obs_e !== exp_vec(1)) begin n_fail++; $display("FAIL rt_exp cyc=%0d: got %h want %h", cyc, obs_e, exp_vec(1)); end
            if (last_sv == 0 && us_l == 3'd3) done = 1;
        end
        n_cmp++;
        if (!done) begin n_fail++; $display("FAIL resustain_timeout: got none want state 3"); end
        gate[0] = 1'b0;
        svc = 0;
        done = 0;
        for (int t = 0; t < 1000 && !done; t++) begin
            tick();
            n_cmp++;
            if (obs_l !== exp_vec(0)) begin n_fail++; $display("FAIL fr_lin cyc=%0d: got %h want %h", cyc, obs_l, exp_vec(0)); end
            if (last_sv == 0) begin
                svc++;
                if (svc > 1 && us_l == 3'd0) done = 1;
            end
        end
        n_cmp += 2;
        if (svc - 1 != 170) begin n_fail++; $display("FAIL release_len: got %0d want 170", svc - 1); end
        if (env_l[7:0] !== 8'h00) begin n_fail++; $display("FAIL release_end_env: got %h want 00", env_l[7:0]); end
    endtask

    task automatic test_rate();
        int times [4];
        int nchg = 0, wr_cyc;
        logic [7:0] prev;
        do_reset();
        cfg_write(0, 0, 8'h20);
        gate[0] = 1'b1;
        prev = env_l[7:0];
        for (int t = 0; t < 200 && nchg < 4; t++) begin
            tick();
            n_cmp++;
            if (obs_l !== exp_vec(0)) begin n_fail++; $display("FAIL rate_lin cyc=%0d: got %h want %h", cyc, obs_l, exp_vec(0)); end
            if (env_l[7:0] != prev) begin times[nchg] = cyc; nchg++; prev = env_l[7:0]; end
        end
        for (int i = 1; i < 4; i++) begin
            n_cmp++;
            if (times[i] - times[i-1] != 12) begin
                n_fail++; $display("FAIL rate2_period: got %0d want 12", times[i] - times[i-1]);
            end
        end
        repeat (4) tick();
        cfg_write(0, 0, 8'h00);
        wr_cyc = cyc;
        prev = env_l[7:0];
        nchg = 0;
        for (int t = 0; t < 100 && nchg < 4; t++) begin
            tick();
            n_cmp++;
            if (obs_l !== exp_vec(0)) begin n_fail++; $display("FAIL rate0_lin cyc=%0d: got %h want %h", cyc, obs_l, exp_vec(0)); end
            if (env_l[7:0] != prev) begin times[nchg] = cyc; nchg++; prev = env_l[7:0]; end
        end
        n_cmp++;
        if (times[0] - wr_cyc > 3) begin n_fail++; $display("FAIL rate_switch: got %0d want <=3", times[0] - wr_cyc); end
        for (int i = 1; i < 4; i++) begin
            n_cmp++;
            if (times[i] - times[i-1] != 3) begin
                n_fail++; $display("FAIL rate0_period: got %0d want 3", times[i] - times[i-1]);
            end
        end
    endtask

    task automatic test_exp_release();
        int svc = 0;
        bit done = 0;
        do_reset();
        cfg_write(0, 0, 8'h00);
        cfg_write(0, 1, 8'h00);
        gate[0] = 1'b1;
        for (int t = 0; t < 1000 && !done; t++) begin
            tick();
            if (env_e[7:0] == 8'h80) done = 1;
        end
        n_cmp++;
        if (!done) begin n_fail++; $display("FAIL exp_attack_timeout: got %h want 80", env_e[7:0]); end
        gate[0] = 1'b0;
        done = 0;
        for (int t = 0; t < 3000 && !done; t++) begin
            tick();
            n_cmp += 2;
            if (obs_l !== exp_vec(0)) begin n_fail++; $display("FAIL xr_lin cyc=%0d: got %h want %h", cyc, obs_l, exp_vec(0)); end
            if (obs_e !== exp_vec(1)) begin n_fail++; $display("FAIL xr_exp cyc=%0d: got %h want %h", cyc, obs_e, exp_vec(1)); end
            if (last_sv == 0) begin
                svc++;
                if (svc > 1 && env_e[7:0] == 8'h00) done = 1;
            end
        end
        n_cmp += 2;
        if (svc - 1 != 737) begin n_fail++; $display("FAIL exp_release_len: got %0d want 737", svc - 1); end
        if (us_e !== 3'd0) begin n_fail++; $display("FAIL exp_release_idle: got %0d want 0", us_e); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        cfg_write(1, 0, 8'hF0);
        for (int t = 0; t < 3 && m_slot != 1; t++) tick();
        gate[1] = 1'b1;
        cfg_we = 1'b1; cfg_voice = 3'd1; cfg_addr = 1'b0; cfg_data = 8'h00;
        tick();
        n_cmp += 3;
        if (uv_l !== 3'd1) begin n_fail++; $display("FAIL sim_voice: got %0d want 1", uv_l); end
        if (us_l !== 3'd1) begin n_fail++; $display("FAIL sim_state: got %0d want 1", us_l); end
        if (env_l[15:8] !== 8'h00) begin n_fail++; $display("FAIL sim_env: got %h want 00", env_l[15:8]); end
        repeat (3) tick();
        n_cmp++;
        if (env_l[15:8] !== 8'h01) begin n_fail++; $display("FAIL sim_next_rate: got %h want 01", env_l[15:8]); end
        cfg_write(5, 0, 8'hF0);
        for (int t = 0; t < 30; t++) begin
            tick();
            n_cmp++;
            if (obs_l !== exp_vec(0)) begin n_fail++; $display("FAIL bad_voice cyc=%0d: got %h want %h", cyc, obs_l, exp_vec(0)); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cfg_write(2, 0, 8'h30);
        cfg_write(2, 0, 8'hF0);
        cfg_write(2, 0, 8'h10);
        gate[2] = 1'b1;
        for (int t = 0; t < 40; t++) begin
            tick();
            n_cmp++;
            if (obs_l !== exp_vec(0)) begin n_fail++; $display("FAIL b2b cyc=%0d: got %h want %h", cyc, obs_l, exp_vec(0)); end
        end
    endtask

    task automatic test_random();
        int a;
        do_reset();
        for (int t = 0; t < 4000; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                a = int'($urandom_range(0, 1));
                cfg_we = 1'b1;
                cfg_voice = 3'($urandom_range(0, 7));
                cfg_addr = a[0];
                cfg_data = {4'((a != 0) ? $urandom_range(0, 15) : $urandom_range(0, 2)),
                            4'($urandom_range(0, 2))};
            end
            if ($urandom_range(0, 59) == 0) begin
                a = int'($urandom_range(0, 2));
                gate[a] = ~gate[a];
            end
            tick();
            n_cmp += 2;
            if (obs_l !== exp_vec(0)) begin n_fail++; $display("FAIL rnd_lin cyc=%0d: got %h want %h", cyc, obs_l, exp_vec(0)); end
            if (obs_e !== exp_vec(1)) begin n_fail++; $display("FAIL rnd_exp cyc=%0d: got %h want %h", cyc, obs_e, exp_vec(1)); end
        end
    endtask

    task automatic test_reset_mid();
        bit done = 0;
        do_reset();
        gate[0] = 1'b1;
        for (int t = 0; t < 400 && !done; t++) begin
            tick();
            if (env_l[7:0] == 8'h37) done = 1;
        end
        n_cmp++;
        if (!done) begin n_fail++; $display("FAIL reach_37: got %h want 37", env_l[7:0]); end
        #2 rst = 1'b1;
        #1;
        n_cmp += 2;
        if (obs_l !== 31'h0) begin n_fail++; $display("FAIL mid_reset_lin: got %h want 0", obs_l); end
        if (obs_e !== 31'h0) begin n_fail++; $display("FAIL mid_reset_exp: got %h want 0", obs_e); end
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        n_cmp += 3;
        if (uv_l !== 3'd0) begin n_fail++; $display("FAIL post_reset_voice: got %0d want 0", uv_l); end
        if (us_l !== 3'd1) begin n_fail++; $display("FAIL post_reset_state: got %0d want 1", us_l); end
        if (env_l !== 24'h0) begin n_fail++; $display("FAIL post_reset_env: got %h want 0", env_l); end
        for (int t = 0; t < 12; t++) begin
            tick();
            n_cmp++;
            if (obs_l !== exp_vec(0)) begin n_fail++; $display("FAIL post_reset cyc=%0d: got %h want %h", cyc, obs_l, exp_vec(0)); end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_attack_decay();
        test_release();
        test_rate();
        test_exp_release();
        test_simultaneous();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
